// File: rtl/bus_arbiter2.sv
// Two-master, one-slave round-robin bus arbiter with one transaction in flight
// and a programmable watchdog that force-completes stalled slave transactions.
module bus_arbiter2 #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_bstart,
    input  logic        m0_ttype,
    input  logic [2:0]  m0_tsize,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_bdone,
    output logic [31:0] m0_rdata,
    input  logic        m1_bstart,
    input  logic        m1_ttype,
    input  logic [2:0]  m1_tsize,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_bdone,
    output logic [31:0] m1_rdata,
    output logic        s_bstart,
    output logic        s_ttype,
    output logic [2:0]  s_tsize,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_bdone,
    input  logic [31:0] s_rdata,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
    localparam bit            WDOG_EN  = (TIMEOUT != 0);

    state_t        state;
    logic          last;
    logic [CW-1:0] cnt;
    logic          granted;
    logic          sel1;
    logic          expire;
    logic          finish;

    assign granted = (state == GNT0) || (state == GNT1);
    assign sel1    = (state == GNT1);
    // A slave completion in the expiry cycle takes precedence over the watchdog.
    assign expire  = WDOG_EN && granted && (cnt == LAST_CNT) && !s_bdone;
    assign finish  = s_bdone || expire;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (m0_bstart && (!m1_bstart || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                    end else if (m1_bstart) begin
                        state <= GNT1;
                        last  <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (finish) state <= IDLE;
                    else        cnt   <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case logic so no latch is inferred.
    always_comb begin
        s_bstart    = 1'b0;
        s_ttype     = 1'b0;
        s_tsize     = 3'd0;
        s_addr      = 32'd0;
        s_wdata     = 32'd0;
        m0_bdone    = 1'b0;
        m0_rdata    = 32'd0;
        m1_bdone    = 1'b0;
        m1_rdata    = 32'd0;
        timeout_err = 1'b0;
        if (granted) begin
            s_bstart    = (sel1 ? m1_bstart : m0_bstart) && !expire;
            s_ttype     = sel1 ? m1_ttype : m0_ttype;
            s_tsize     = sel1 ? m1_tsize : m0_tsize;
            s_addr      = sel1 ? m1_addr  : m0_addr;
            s_wdata     = sel1 ? m1_wdata : m0_wdata;
            timeout_err = expire;
            if (sel1) begin
                m1_bdone = finish;
                m1_rdata = expire ? 32'd0 : s_rdata;
            end else begin
                m0_bdone = finish;
                m0_rdata = expire ? 32'd0 : s_rdata;
            end
        end
    end

endmodule
